// File: rtl/exception_vector_sequencer.sv
// exception_vector_sequencer: saves EPC, reads the handler byte at the cause's vector and loads PC.
// Defining EXC_CAUSE_REG_EN adds the o_cause and o_exc_lost outputs.
module exception_vector_sequencer #(
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255,
    parameter int          MEM_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_exc_opcode,
    input  logic        i_exc_ovf,
    input  logic        i_exc_div0,
    input  logic [31:0] i_pc_in,
    input  logic [31:0] i_ext_result,
    output logic        o_ext_sel,
    output logic        o_mem_rd,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_epc_out,
    output logic        o_epc_write,
    output logic [31:0] o_pc_out,
    output logic        o_pc_write,
`ifdef EXC_CAUSE_REG_EN
    output logic [1:0]  o_cause,
    output logic        o_exc_lost,
`endif
    output logic        o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_SAVE, S_WAIT, S_LOAD} state_t;
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        w_any, w_accept, w_last;
    logic [1:0]  w_cause;
    logic [31:0] w_vec;

    // Priority opcode > ovf > div0; cause code doubles as vector selector.
    assign w_any    = i_exc_opcode | i_exc_ovf | i_exc_div0;
    assign w_accept = (r_state == S_IDLE) && w_any;
    assign w_last   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_cause  = i_exc_opcode ? 2'd1 : i_exc_ovf ? 2'd2 : 2'd3;
    assign w_vec    = i_exc_opcode ? VEC_OPCODE : i_exc_ovf ? VEC_OVF : VEC_DIV0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == S_IDLE) ? (w_any ? S_SAVE : S_IDLE) :
                 (r_state == S_SAVE) ? S_WAIT :
                 (r_state == S_WAIT) ? (w_last ? S_LOAD : S_WAIT) : S_IDLE;
    end

    always_comb begin
        o_busy      = r_state != S_IDLE;
        o_ext_sel   = o_busy;
        o_epc_write = r_state == S_SAVE;
        o_mem_rd    = (r_state == S_SAVE) || (r_state == S_WAIT);
        o_pc_write  = r_state == S_LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 4'd0;
            o_epc_out  <= 32'd0;
            o_mem_addr <= 32'd0;
            o_pc_out   <= 32'd0;
        end else begin
            if (w_accept) begin
                o_epc_out  <= i_pc_in - 32'd4;
                o_mem_addr <= w_vec;
            end
            if (r_state == S_SAVE)
                r_cnt <= LAT_M1;
            else if (r_state == S_WAIT && !w_last)
                r_cnt <= r_cnt - 4'd1;
            if (w_last)
                o_pc_out <= i_ext_result;
        end
    end

`ifdef EXC_CAUSE_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cause    <= 2'd0;
            o_exc_lost <= 1'b0;
        end else begin
            if (w_accept)
                o_cause <= w_cause;
            if (o_busy && w_any)
                o_exc_lost <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_exception_vector_sequencer.sv
// tb_exception_vector_sequencer: two DUTs (MEM_LAT 1 and 4) against a timeline-based reference model.
module tb_exception_vector_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op, ov, dz;
    logic [31:0] pc_in;
    logic [31:0] ext [2];
    logic        sel [2], rd [2], ew [2], pw [2], bz [2];
    logic [31:0] addr [2], epc [2], pco [2];
    logic [1:0]  cs [2];
    logic        lst [2];
    logic [7:0]  mem [256];
    int          rc0, rc1;

    int          lat [2];
    int          s [2];
    int          cyc;
    logic [31:0] e_epc [2], e_addr [2], e_pc [2];
    logic [1:0]  e_cause [2];
    logic        e_lost [2];
    int          checks, errors;

    always #5 clk = ~clk;

    exception_vector_sequencer #(.MEM_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .i_exc_opcode(op), .i_exc_ovf(ov), .i_exc_div0(dz),
        .i_pc_in(pc_in), .i_ext_result(ext[0]), .o_ext_sel(sel[0]), .o_mem_rd(rd[0]),
        .o_mem_addr(addr[0]), .o_epc_out(epc[0]), .o_epc_write(ew[0]), .o_pc_out(pco[0]),
        .o_pc_write(pw[0]),
`ifdef EXC_CAUSE_REG_EN
        .o_cause(cs[0]), .o_exc_lost(lst[0]),
`endif
        .o_busy(bz[0]));

    exception_vector_sequencer #(.MEM_LAT(4)) u4 (
        .clk(clk), .rst_n(rst_n), .i_exc_opcode(op), .i_exc_ovf(ov), .i_exc_div0(dz),
        .i_pc_in(pc_in), .i_ext_result(ext[1]), .o_ext_sel(sel[1]), .o_mem_rd(rd[1]),
        .o_mem_addr(addr[1]), .o_epc_out(epc[1]), .o_epc_write(ew[1]), .o_pc_out(pco[1]),
        .o_pc_write(pw[1]),
`ifdef EXC_CAUSE_REG_EN
        .o_cause(cs[1]), .o_exc_lost(lst[1]),
`endif
        .o_busy(bz[1]));

    // Memory returns the zero-extended byte only once the read has been held for the latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc0 <= 0;
            rc1 <= 0;
        end else begin
            rc0 <= rd[0] ? rc0 + 1 : 0;
            rc1 <= rd[1] ? rc1 + 1 : 0;
        end
    end
    assign ext[0] = (rc0 >= 1) ? {24'h0, mem[addr[0][7:0]]} : 32'hFFFF_8123;
    assign ext[1] = (rc1 >= 4) ? {24'h0, mem[addr[1][7:0]]} : 32'hFFFF_8123;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            s[i] = -100;
            e_epc[i] = 0;
            e_addr[i] = 0;
            e_pc[i] = 0;
            e_cause[i] = 0;
            e_lost[i] = 0;
        end
    endtask

    // A sequence accepted at edge s occupies cycles s..s+L+1: SAVE at offset 0, reads through L, LOAD at L+1.
    task automatic model_edge();
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int d;
            d = cyc - s[i];
            if (d >= 1 && d <= lat[i] + 2) begin
                if (op | ov | dz) e_lost[i] = 1;
                if (d == lat[i] + 1) e_pc[i] = {24'h0, mem[e_addr[i][7:0]]};
            end else if (op | ov | dz) begin
                s[i] = cyc;
                e_cause[i] = op ? 2'd1 : ov ? 2'd2 : 2'd3;
                e_epc[i] = pc_in - 32'd4;
                e_addr[i] = op ? 32'd253 : ov ? 32'd254 : 32'd255;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int d;
            d = cyc - s[i];
            if (!rst_n) d = -1;
            chk($sformatf("u%0d.epc_write", i), 32'(ew[i]), 32'(d == 0));
            chk($sformatf("u%0d.mem_rd", i), 32'(rd[i]), 32'(d >= 0 && d <= lat[i]));
            chk($sformatf("u%0d.pc_write", i), 32'(pw[i]), 32'(d == lat[i] + 1));
            chk($sformatf("u%0d.busy", i), 32'(bz[i]), 32'(d >= 0 && d <= lat[i] + 1));
            chk($sformatf("u%0d.ext_sel", i), 32'(sel[i]), 32'(d >= 0 && d <= lat[i] + 1));
            chk($sformatf("u%0d.epc_out", i), epc[i], e_epc[i]);
            chk($sformatf("u%0d.mem_addr", i), addr[i], e_addr[i]);
            chk($sformatf("u%0d.pc_out", i), pco[i], e_pc[i]);
`ifdef EXC_CAUSE_REG_EN
            chk($sformatf("u%0d.cause", i), 32'(cs[i]), 32'(e_cause[i]));
            chk($sformatf("u%0d.exc_lost", i), 32'(lst[i]), 32'(e_lost[i]));
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drv(input logic a, input logic b, input logic c, input logic [31:0] p);
        op = a;
        ov = b;
        dz = c;
        pc_in = p;
    endtask

    task automatic run_one(input logic a, input logic b, input logic c, input logic [31:0] p);
        drv(a, b, c, p);
        step();
        drv(0, 0, 0, $urandom);
        repeat (8) step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        lat[0] = 1;
        lat[1] = 4;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        mem[253] = 8'h8C;
        mem[255] = 8'hFF;
        drv(0, 0, 0, 0);
        model_reset();
        #1 check_all();
        repeat (2) @(negedge clk);
        rst_n = 1;
        run_one(1, 0, 0, 32'h0000_0010);
        run_one(0, 1, 1, $urandom);
        run_one(1, 1, 1, $urandom);
        run_one(0, 0, 1, 32'h0);
        // Second ovf pulse lands while busy and must be dropped.
        drv(0, 1, 0, $urandom);
        step();
        drv(0, 0, 0, 0);
        step();
        drv(0, 1, 0, $urandom);
        step();
        drv(0, 0, 0, 0);
        repeat (8) step();
        drv(0, 1, 0, $urandom);
        repeat (14) step();
        drv(0, 0, 0, 0);
        repeat (8) step();
        // Abort in WAIT with an asynchronous reset, then a clean ovf sequence.
        drv(0, 0, 1, $urandom);
        step();
        drv(0, 0, 0, 0);
        step();
        rst_n = 0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1;
        run_one(0, 1, 0, $urandom);
        repeat (400) begin
            drv($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom);
            step();
        end
        drv(0, 0, 0, 0);
        repeat (8) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
